// File: rtl/fa_pkg.sv
// fa_pkg: shared definitions for the cross-checked full-adder set.
//   FA_SUM_TT / FA_CO_TT : expected sum / carry-out truth tables, bit index
//                          is the operand code {ci, a, b}.
//   fa_code()            : packs the three operand bits into that index.
package fa_pkg;

  localparam logic [7:0] FA_SUM_TT = 8'b1001_0110;
  localparam logic [7:0] FA_CO_TT  = 8'b1110_1000;

  function automatic logic [2:0] fa_code(input logic ci, input logic a, input logic b);
    return {ci, a, b};
  endfunction

endpackage

// File: rtl/fa_behavior.sv
// fa_behavior: 1-bit full adder written as a 2-bit arithmetic add.
//   a, b, ci : operand bits
//   s, co    : sum and carry-out
module fa_behavior (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
  end

endmodule

// File: rtl/fa_case.sv
// fa_case: 1-bit full adder written as a truth-table case over {ci, a, b}.
//   a, b, ci : operand bits
//   s, co    : sum and carry-out
// Unknown operand codes fall through to the default arm and give 00.
module fa_case
  import fa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    {co, s} = 2'b00;
    case (fa_code(ci, a, b))
      3'b000:  {co, s} = {FA_CO_TT[0], FA_SUM_TT[0]};
      3'b001:  {co, s} = {FA_CO_TT[1], FA_SUM_TT[1]};
      3'b010:  {co, s} = {FA_CO_TT[2], FA_SUM_TT[2]};
      3'b011:  {co, s} = {FA_CO_TT[3], FA_SUM_TT[3]};
      3'b100:  {co, s} = {FA_CO_TT[4], FA_SUM_TT[4]};
      3'b101:  {co, s} = {FA_CO_TT[5], FA_SUM_TT[5]};
      3'b110:  {co, s} = {FA_CO_TT[6], FA_SUM_TT[6]};
      3'b111:  {co, s} = {FA_CO_TT[7], FA_SUM_TT[7]};
      default: {co, s} = 2'b00;
    endcase
  end

endmodule

// File: rtl/fa_dataflow.sv
// fa_dataflow: 1-bit full adder written as continuous-assign equations.
//   a, b, ci : operand bits
//   s, co    : sum and carry-out
module fa_dataflow (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term shared by sum and carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_set.sv
// full_adder_set: three independently written 1-bit full adders fed the same
// operands, with registered results and a disagreement monitor.
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   in_valid, a, b, ci: operand set, qualified by in_valid
//   out_valid         : registered results come from a valid operand set
//   s1/co1            : dataflow core result (registered)
//   s2/co2            : behavioral core result (registered)
//   s3/co3            : case core result (registered)
//   mismatch          : cores disagree on the current registered result
//   err_sticky        : latched mismatch, cleared only by reset
module full_adder_set (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic out_valid,
  output logic s1,
  output logic co1,
  output logic s2,
  output logic co2,
  output logic s3,
  output logic co3,
  output logic mismatch,
  output logic err_sticky
);

  logic df_s, df_co;
  logic bh_s, bh_co;
  logic case_s, case_co;

  fa_dataflow u_dataflow (.a(a), .b(b), .ci(ci), .s(df_s),   .co(df_co));
  fa_behavior u_behavior (.a(a), .b(b), .ci(ci), .s(bh_s),   .co(bh_co));
  fa_case     u_case     (.a(a), .b(b), .ci(ci), .s(case_s), .co(case_co));

  // Results hold while in_valid is low; only out_valid tracks it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      s1         <= 1'b0;
      co1        <= 1'b0;
      s2         <= 1'b0;
      co2        <= 1'b0;
      s3         <= 1'b0;
      co3        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s1  <= df_s;
        co1 <= df_co;
        s2  <= bh_s;
        co2 <= bh_co;
        s3  <= case_s;
        co3 <= case_co;
      end
      if (mismatch) begin
        err_sticky <= 1'b1;
      end
    end
  end

  always_comb begin
    mismatch = out_valid & ((s1 != s2) | (s1 != s3) | (co1 != co2) | (co1 != co3));
  end

endmodule

// File: tb/tb_full_adder_set.sv
module tb_full_adder_set;

  logic clk = 1'b0;
  logic rst_n, in_valid, a, b, ci;
  logic out_valid, s1, co1, s2, co2, s3, co3, mismatch, err_sticky;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit fault  = 1'b0;

  // Hand-computed {co, s} for each operand code {ci, a, b}.
  localparam logic [1:0] EXP_TT [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                        2'b01, 2'b10, 2'b10, 2'b11};

  always #5 clk = ~clk;

  full_adder_set dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid), .s1(s1), .co1(co1), .s2(s2), .co2(co2),
    .s3(s3), .co3(co3), .mismatch(mismatch), .err_sticky(err_sticky)
  );

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each core result is the plain sum a+b+ci; a fault
  // flag models the inverted case-core sum during injection.
  logic       m_valid, m_sticky;
  logic [1:0] m_res [3];

  function automatic logic m_disagree();
    return m_valid && (m_res[0] != m_res[1] || m_res[0] != m_res[2]);
  endfunction

  always @(posedge clk) begin
    int t;
    if (!rst_n) begin
      m_valid  = 1'b0;
      m_sticky = 1'b0;
      for (int k = 0; k < 3; k++) m_res[k] = 2'b00;
    end else begin
      if (m_disagree()) m_sticky = 1'b1;
      m_valid = in_valid;
      if (in_valid) begin
        t = int'(a) + int'(b) + int'(ci);
        for (int k = 0; k < 3; k++) m_res[k] = t[1:0];
        if (fault) m_res[2][0] = ~m_res[2][0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid",    {1'b0, out_valid},  {1'b0, m_valid});
      chk("model_core1",    {co1, s1},          m_res[0]);
      chk("model_core2",    {co2, s2},          m_res[1]);
      chk("model_core3",    {co3, s3},          m_res[2]);
      chk("model_mismatch", {1'b0, mismatch},   {1'b0, m_disagree()});
      chk("model_sticky",   {1'b0, err_sticky}, {1'b0, m_sticky});
    end
  end

  // Drive one operand set, then return at the next negedge where its
  // registered result is visible.
  task automatic drive(input logic v, input logic [2:0] code);
    {ci, a, b} = code;
    in_valid   = v;
    @(negedge clk);
  endtask

  task automatic chk_all(input string name, input logic [1:0] exp);
    chk({name, "_c1"}, {co1, s1}, exp);
    chk({name, "_c2"}, {co2, s2}, exp);
    chk({name, "_c3"}, {co3, s3}, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; ci = 1'b0;
    @(negedge clk);
    drive(1'b0, 3'b000);
    drive(1'b1, 3'b111);
    chk_all("rst_init", 2'b00);
    chk("rst_init_valid",  {1'b0, out_valid},  2'b00);
    chk("rst_init_sticky", {1'b0, err_sticky}, 2'b00);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Exhaustive sweep, one code per clock.
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 3'(c));
      chk_all($sformatf("sweep%0d", c), EXP_TT[c]);
      chk("sweep_mm", {1'b0, mismatch}, 2'b00);
    end

    // Back-to-back.
    drive(1'b1, 3'b111);
    chk_all("b2b_111", 2'b11);
    drive(1'b1, 3'b000);
    chk_all("b2b_000", 2'b00);
    chk("b2b_valid", {1'b0, out_valid}, 2'b01);

    // Hold while in_valid is low.
    drive(1'b1, 3'b011);
    chk_all("hold_load", 2'b10);
    drive(1'b0, 3'b100);
    chk_all("hold_keep", 2'b10);
    chk("hold_valid", {1'b0, out_valid}, 2'b00);

    // Fault injection on the case core sum (true sum for 001 is 1).
    force dut.case_s = 1'b0;
    fault = 1'b1;
    drive(1'b1, 3'b001);
    chk("fault_mm",     {1'b0, mismatch},   2'b01);
    chk("fault_s3",     {co3, s3},          2'b00);
    chk("fault_s1",     {co1, s1},          2'b01);
    chk("fault_sticky0",{1'b0, err_sticky}, 2'b00);
    release dut.case_s;
    fault = 1'b0;
    drive(1'b1, 3'b011);
    chk("fault_sticky1", {1'b0, err_sticky}, 2'b01);
    chk("fault_mm_gone", {1'b0, mismatch},   2'b00);
    drive(1'b1, 3'b111);
    chk("fault_sticky2", {1'b0, err_sticky}, 2'b01);
    chk_all("fault_after", 2'b11);

    // Reset with a valid operand pending; no effect until the edge.
    {ci, a, b} = 3'b111; in_valid = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_midcycle_s1",     {co1, s1},          2'b11);
    chk("rst_midcycle_sticky", {1'b0, err_sticky}, 2'b01);
    @(negedge clk);
    chk_all("rst_drop", 2'b00);
    chk("rst_valid",  {1'b0, out_valid},  2'b00);
    chk("rst_sticky", {1'b0, err_sticky}, 2'b00);
    chk("rst_mm",     {1'b0, mismatch},   2'b00);
    rst_n = 1'b1;
    drive(1'b1, 3'b110);
    chk_all("resume", 2'b10);
    chk("resume_valid", {1'b0, out_valid}, 2'b01);
    drive(1'b0, 3'b000);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
